pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator that succeeds the single-register PC at the front of the five-stage RV32IM fetch stage.
- Adds a post-reset boot delay, stall hold, redirect (branch/jump from EX) and trap redirect with fixed priority, halt/resume control, misaligned-target detection and a fetch counter.
- Drives the instruction-memory address and the PC+4 value forwarded to IF/ID.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value held during and after reset.
- BOOT_DELAY, 2, cycles after reset release before the first valid fetch; 0 is legal.
- ALIGN_BITS, 2, low target bits that must be zero (2 = no compressed ISA).
- CNT_W, 32, fetch counter width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- stall_i  input  1  hazard stall; hold the PC
- redirect_valid_i  input  1  branch/jump taken in EX
- redirect_target_i  input  XLEN  branch/jump target
- trap_valid_i  input  1  trap or exception entry
- trap_target_i  input  XLEN  trap vector (mtvec)
- halt_req_i  input  1  request to stop fetching
- resume_i  input  1  leave HALT
- pc_o  output  XLEN  current fetch PC (registered)
- pc_plus4_o  output  XLEN  pc_o + 4, combinational, mod 2^XLEN
- pc_valid_o  output  1  pc_o is a real fetch this cycle
- misalign_o  output  1  one-cycle pulse: rejected misaligned redirect target
- bad_addr_o  output  XLEN  last rejected target (registered)
- halted_o  output  1  state == HALT
- fetch_cnt_o  output  CNT_W  accepted fetches, wraps

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately, including mid-operation):
  - pc_o=RESET_VECTOR, state=BOOT, boot counter=BOOT_DELAY.
  - pc_valid_o=0, misalign_o=0, bad_addr_o=0, halted_o=0, fetch_cnt_o=0.
- State machine: BOOT, RUN, HALT.
  - BOOT: pc_valid_o=0. The counter decrements each clock after reset release; BOOT->RUN on the edge where the counter is 0. With BOOT_DELAY=0, RUN is entered on the first edge. All control inputs are ignored in BOOT.
  - RUN: pc_valid_o=1. Next-PC priority, highest first:
    1. trap_valid_i: pc<=trap_target_i (no alignment check).
    2. redirect_valid_i: if target[ALIGN_BITS-1:0]!=0, pc holds, misalign_o=1 next cycle, bad_addr_o<=target; otherwise pc<=target.
    3. halt_req_i: pc holds, RUN->HALT.
    4. stall_i: pc holds.
    5. Otherwise pc<=pc+4, wrapping mod 2^XLEN.
  - Trap or redirect wins over a simultaneous stall_i (flush beats stall). A halt_req_i coinciding with a trap or redirect: the redirect is taken and the state still moves to HALT. resume_i is ignored in RUN.
  - HALT: pc_valid_o=0, halted_o=1. Trap and redirect still update pc_o under the same rules, and the state stays HALT. resume_i moves HALT->RUN on the next edge; if halt_req_i and resume_i are both high, resume wins. stall_i is ignored.
- Latency: an event sampled at edge N is visible on pc_o after edge N. misalign_o is high for exactly one cycle after the offending edge.
- fetch_cnt_o increments on every edge where pc_valid_o=1 and stall_i=0, including cycles that redirect. It wraps at 2^CNT_W.
- No combinational path from any input to pc_o, pc_valid_o or halted_o.

Decomposition:
- Shared package pc_pkg:
  - state enum {BOOT, RUN, HALT}
  - constant PC_INC=4
  - XLEN default
- Sub-module pc_next_sel, purely combinational: priority mux plus alignment check, producing next_pc, take and misalign.
- pc_gen holds the registers, the FSM and the counters.

Test Plan:
- Reset then release with BOOT_DELAY=2: pc_valid_o=0 for 2 edges, then pc_o sequence 0x0, 0x4, 0x8; fetch_cnt_o=3 after three unstalled valid cycles.
- Redirect 0x100 with stall_i=1 at pc=0x8 -> pc_o=0x100 next cycle, then 0x104 once stall drops.
- Redirect 0x102 -> pc_o holds, misalign_o pulses for exactly 1 cycle, bad_addr_o=0x102. Then trap 0x80 together with redirect 0x200 -> pc_o=0x80.
- Start at pc=0xFFFF_FFFC, unstalled -> next pc_o=0x0, pc_plus4_o=0x4.
- halt_req_i at pc=0x20 -> halted_o=1 and pc_o stays 0x20 for 5 cycles; redirect 0x40 while halted -> pc_o=0x40, still halted; resume_i -> RUN, pc_o=0x40 then 0x44.
- Drop reset_n asynchronously mid-RUN at pc=0x54 -> pc_o=RESET_VECTOR and pc_valid_o=0 immediately, without waiting for a clock edge; the BOOT delay repeats after release.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// Holds the FSM encoding, the sequential PC increment and the default width.
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_INC       = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_gen_if.sv
// Control and fetch-address bundle between pipeline control and pc_gen.
// The master side steers the PC; the slave side (pc_gen) drives the fetch address.
interface pc_gen_if #(
  parameter int unsigned XLEN  = pc_pkg::XLEN_DEFAULT,
  parameter int unsigned CNT_W = 32
);

  logic             stall_i;
  logic             redirect_valid_i;
  logic [XLEN-1:0]  redirect_target_i;
  logic             trap_valid_i;
  logic [XLEN-1:0]  trap_target_i;
  logic             halt_req_i;
  logic             resume_i;

  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_plus4_o;
  logic             pc_valid_o;
  logic             misalign_o;
  logic [XLEN-1:0]  bad_addr_o;
  logic             halted_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    output stall_i, redirect_valid_i, redirect_target_i,
           trap_valid_i, trap_target_i, halt_req_i, resume_i,
    input  pc_o, pc_plus4_o, pc_valid_o, misalign_o,
           bad_addr_o, halted_o, fetch_cnt_o
  );

  modport slave (
    input  stall_i, redirect_valid_i, redirect_target_i,
           trap_valid_i, trap_target_i, halt_req_i, resume_i,
    output pc_o, pc_plus4_o, pc_valid_o, misalign_o,
           bad_addr_o, halted_o, fetch_cnt_o
  );

endinterface : pc_gen_if

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: trap > redirect > hold > sequential.
// A misaligned redirect is rejected and leaves the PC where it is.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            take_o,
  output logic            misalign_o
);

  logic redirect_bad;

  assign redirect_bad = |redirect_target_i[ALIGN_BITS-1:0];

  // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_pc_o  = pc_i + XLEN'(PC_INC);
    take_o     = 1'b0;
    misalign_o = 1'b0;
    if (trap_valid_i) begin
      next_pc_o = trap_target_i;
      take_o    = 1'b1;
    end else if (redirect_valid_i) begin
      if (redirect_bad) begin
        next_pc_o  = pc_i;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = redirect_target_i;
        take_o    = 1'b1;
      end
    end else if (hold_i) begin
      next_pc_o = pc_i;
    end
  end

endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot delay, redirect/trap steering,
// halt/resume control, misaligned-target capture and a fetch counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BOOT_DELAY   = 2,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_gen_if.slave  bus
);

  localparam int unsigned BOOT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]        state_q,     state_d;
  logic [BOOT_W-1:0] boot_cnt_q,  boot_cnt_d;
  logic [XLEN-1:0]   pc_q,        pc_d;
  logic              misalign_q,  misalign_d;
  logic [XLEN-1:0]   bad_addr_q,  bad_addr_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic [XLEN-1:0]   sel_next_pc;
  logic              sel_take;
  logic              sel_misalign;
  logic              sel_hold;

  // Sequential advance only happens in RUN with no halt request or stall.
  assign sel_hold = (state_q != ST_RUN) | bus.halt_req_i | bus.stall_i;

  pc_next_sel #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_next_sel (
    .pc_i              (pc_q),
    .trap_valid_i      (bus.trap_valid_i),
    .trap_target_i     (bus.trap_target_i),
    .redirect_valid_i  (bus.redirect_valid_i),
    .redirect_target_i (bus.redirect_target_i),
    .hold_i            (sel_hold),
    .next_pc_o         (sel_next_pc),
    .take_o            (sel_take),
    .misalign_o        (sel_misalign)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    bad_addr_d  = bad_addr_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - BOOT_W'(1);
      end
      ST_RUN: begin
        pc_d       = sel_next_pc;
        misalign_d = sel_misalign;
        // A halt request still lands in HALT when a trap or redirect is taken.
        if (bus.halt_req_i) state_d = ST_HALT;
        if (!bus.stall_i)   fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
      ST_HALT: begin
        pc_d       = sel_next_pc;
        misalign_d = sel_misalign;
        if (bus.resume_i) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase

    if (misalign_d) bad_addr_d = bus.redirect_target_i;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= BOOT_W'(BOOT_DELAY);
      pc_q        <= RESET_VECTOR;
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_plus4_o  = pc_q + XLEN'(PC_INC);
  assign bus.pc_valid_o  = (state_q == ST_RUN);
  assign bus.halted_o    = (state_q == ST_HALT);
  assign bus.misalign_o  = misalign_q;
  assign bus.bad_addr_o  = bad_addr_q;
  assign bus.fetch_cnt_o = fetch_cnt_q;

  // sel_take is informational: the chosen next_pc already folds it in.
  logic unused_take;
  assign unused_take = sel_take;

endmodule : pc_gen
